reg_bus_master: RTL and testbench
=================================

REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter RD_LAT, default 0, meaning extra wait cycles after rd_en before read_data is sampled (0..15).
REQ-002 SHALL have parameter POLL_MAX, default 1024, meaning maximum read attempts per poll command (>=1).
REQ-003 SHALL have parameter POLL_GAP, default 4, meaning idle cycles between poll attempts (>=0).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-005 cmd_valid  in  1  command request; cmd_ready  out  1  command accept.
REQ-006 cmd_op  in  2  command: 00 write, 01 read, 10 poll, 11 reserved.
REQ-007 cmd_addr  in  14  register address; cmd_wdata  in  16  write data or poll expected value; cmd_mask  in  16  poll compare mask.
REQ-008 rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  16  read/poll data; rsp_err  out  1  timeout or reserved op.
REQ-009 wr_en  out  1; rd_en  out  1; addr  out  14; write_data  out  16; read_data  in  16  combinational responder data.
REQ-010 busy  out  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, READ, WAIT, GAP, RESP; one command outstanding at a time.
REQ-012 IDLE: cmd_ready=1; all other states: cmd_ready=0; capture op/addr/wdata/mask on cmd_valid&&cmd_ready.
REQ-013 From IDLE: write->WRITE, read or poll->READ, reserved->RESP with rsp_err=1, rsp_rdata=0.
REQ-014 WRITE: wr_en=1 for exactly one cycle with captured addr/write_data, then RESP with rsp_rdata=0, rsp_err=0.
REQ-015 READ: rd_en=1 for exactly one cycle; RD_LAT=0: sample read_data at that edge; else WAIT for RD_LAT cycles, addr held, sample at the final WAIT edge.
REQ-016 Read: after sample go to RESP, rsp_rdata=sample, rsp_err=0.
REQ-017 Poll: match if (sample & mask)==(wdata & mask); match->RESP err=0; miss with attempts==POLL_MAX->RESP err=1, rdata=last sample; else GAP for POLL_GAP cycles (skip GAP if 0) then READ.
REQ-018 Attempt counter SHALL count sampled reads, width $clog2(POLL_MAX+1), clear on command capture, never wrap.
REQ-019 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready; then IDLE; new cmd acceptable the cycle after.
REQ-020 Write latency: handshake edge N -> wr_en high cycle N+1 -> rsp_valid high cycle N+2.
REQ-021 Read latency (RD_LAT=0): handshake edge N -> rd_en cycle N+1 -> rsp_valid cycle N+2.
REQ-022 wr_en and rd_en SHALL never be high simultaneously and SHALL be 0 in IDLE, WAIT, GAP, RESP.
REQ-023 addr/write_data SHALL hold captured values from capture until next capture.

Reset
REQ-024 On rst_n low (any state, mid-command included): state IDLE, wr_en=0, rd_en=0, addr=0, write_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counters 0; in-flight command discarded without response.
REQ-025 cmd_ready SHALL be 0 while rst_n low and 1 the first cycle after release.

Configuration
REQ-026 Macro REG_BUS_MASTER_POLL_EN defined: poll op, GAP state, attempt counter present per REQ-017/018.
REQ-027 Macro undefined: op 10 treated as reserved (RESP, err=1, rdata=0); no poll counter or GAP logic synthesised.

Structure
REQ-028 Package reg_bus_pkg SHALL hold REG_ADDR_W=14, REG_DATA_W=16, cmd op enum, FSM state enum.
REQ-029 No sub-module; counter and FSM live in reg_bus_master.

Verification
REQ-030 Write op addr 0x101 wdata 0x0020 -> one-cycle wr_en, addr 0x101, write_data 0x0020; rsp_valid 2 cycles after handshake, err 0.
REQ-031 Read 0x111, responder drives 0x0003, RD_LAT=0 and RD_LAT=2 -> rsp_rdata 0x0003, rsp_valid at N+2 and N+4.
REQ-032 Poll 0x111 mask 0x000F exp 0x0001, status becomes 0x0001 before 3rd read -> 3 rd_en pulses POLL_GAP apart, rsp err 0 rdata 0x0001.
REQ-033 Poll POLL_MAX=4, status stuck 0x0000 -> exactly 4 rd_en pulses, rsp err 1 rdata 0x0000; macro undefined -> immediate err 1, no rd_en.
REQ-034 rsp_ready held low 10 cycles -> rsp_valid/data stable, cmd_ready 0; rst_n asserted during WAIT -> all outputs 0 immediately, no response after release.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared widths, command opcodes and FSM state encoding for the register bus master.
package reg_bus_pkg;

    localparam int REG_ADDR_W = 14;
    localparam int REG_DATA_W = 16;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_GAP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/reg_bus_master.sv
// Single-outstanding register bus master: write, read and (with REG_BUS_MASTER_POLL_EN)
// poll-until-match commands against a combinational register responder.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int RD_LAT   = 0,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_addr,
    input  logic [REG_DATA_W-1:0] cmd_wdata,
    input  logic [REG_DATA_W-1:0] cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [REG_ADDR_W-1:0] addr,
    output logic [REG_DATA_W-1:0] write_data,
    input  logic [REG_DATA_W-1:0] read_data,
    output logic                  busy
);

    localparam logic [3:0] LAT_LAST = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_e                  state_reg, state_next;
    logic [REG_ADDR_W-1:0]   addr_reg, addr_next;
    logic [REG_DATA_W-1:0]   wdata_reg, wdata_next;
    logic [REG_DATA_W-1:0]   rdata_reg, rdata_next;
    logic                    err_reg, err_next;
    logic [3:0]              lat_cnt_reg, lat_cnt_next;
    logic                    sample_now;

`ifdef REG_BUS_MASTER_POLL_EN
    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(POLL_MAX);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    logic                    is_poll_reg, is_poll_next;
    logic [REG_DATA_W-1:0]   mask_reg, mask_next;
    logic [ATT_W-1:0]        att_reg, att_next, att_inc;
    logic [GAP_W-1:0]        gap_cnt_reg, gap_cnt_next;
    logic                    poll_hit;

    // Attempt counter saturates rather than wrapping.
    assign att_inc  = (att_reg == ATT_MAX) ? att_reg : att_reg + ATT_W'(1);
    assign poll_hit = ((read_data ^ wdata_reg) & mask_reg) == '0;
`else
    logic unused_mask;
    assign unused_mask = ^cmd_mask;
`endif

    // read_data is taken at the last edge of the access: READ itself when RD_LAT is 0.
    assign sample_now = ((state_reg == ST_READ) && (RD_LAT == 0)) ||
                        ((state_reg == ST_WAIT) && (lat_cnt_reg == LAT_LAST));

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        lat_cnt_next = lat_cnt_reg;
`ifdef REG_BUS_MASTER_POLL_EN
        is_poll_next = is_poll_reg;
        mask_next    = mask_reg;
        att_next     = att_reg;
        gap_cnt_next = gap_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    wdata_next = cmd_wdata;
`ifdef REG_BUS_MASTER_POLL_EN
                    mask_next    = cmd_mask;
                    att_next     = '0;
                    is_poll_next = (cmd_op == OP_POLL);
`endif
                    case (cmd_op)
                        OP_WRITE: state_next = ST_WRITE;
                        OP_READ:  state_next = ST_READ;
`ifdef REG_BUS_MASTER_POLL_EN
                        OP_POLL:  state_next = ST_READ;
`endif
                        default: begin
                            rdata_next = '0;
                            err_next   = 1'b1;
                            state_next = ST_RESP;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                rdata_next = '0;
                err_next   = 1'b0;
                state_next = ST_RESP;
            end
            ST_READ: begin
                if (RD_LAT != 0) begin
                    lat_cnt_next = '0;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_reg != LAT_LAST) begin
                    lat_cnt_next = lat_cnt_reg + 4'd1;
                end
            end
`ifdef REG_BUS_MASTER_POLL_EN
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_READ;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (sample_now) begin
            rdata_next = read_data;
            err_next   = 1'b0;
            state_next = ST_RESP;
`ifdef REG_BUS_MASTER_POLL_EN
            if (is_poll_reg) begin
                att_next = att_inc;
                if (!poll_hit) begin
                    if (att_inc == ATT_MAX) begin
                        err_next = 1'b1;
                    end else if (POLL_GAP == 0) begin
                        state_next = ST_READ;
                    end else begin
                        gap_cnt_next = '0;
                        state_next   = ST_GAP;
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            lat_cnt_reg <= '0;
`ifdef REG_BUS_MASTER_POLL_EN
            is_poll_reg <= 1'b0;
            mask_reg    <= '0;
            att_reg     <= '0;
            gap_cnt_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            lat_cnt_reg <= lat_cnt_next;
`ifdef REG_BUS_MASTER_POLL_EN
            is_poll_reg <= is_poll_next;
            mask_reg    <= mask_next;
            att_reg     <= att_next;
            gap_cnt_reg <= gap_cnt_next;
`endif
        end
    end

    // Gating with rst_n keeps the master from accepting commands while held in reset.
    assign cmd_ready  = rst_n && (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign wr_en      = (state_reg == ST_WRITE);
    assign rd_en      = (state_reg == ST_READ);
    assign rsp_valid  = (state_reg == ST_RESP);
    assign rsp_rdata  = rdata_reg;
    assign rsp_err    = err_reg;
    assign addr       = addr_reg;
    assign write_data = wdata_reg;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: two instances (RD_LAT 0 / 2) against a register-file responder
// and a command-level reference model.
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    localparam int PM = 4;
    localparam int L0 = 0;
    localparam int L1 = 2;
    localparam int G0 = 2;
    localparam int G1 = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [13:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [15:0] cmd_mask = '0;

    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        wr_en     [2];
    logic        rd_en     [2];
    logic [13:0] addr      [2];
    logic [15:0] write_data[2];
    logic [15:0] read_data [2];
    logic        busy      [2];

    logic [15:0] slave_mem [2][0:16383];
    logic [15:0] model_mem [2][0:16383];

    logic        flip_en = 1'b0;
    int          flip_after = 0;
    logic [13:0] flip_addr = '0;
    logic [15:0] flip_val = '0;
    int          rd_pulses [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_bus_master #(.RD_LAT(L0), .POLL_MAX(PM), .POLL_GAP(G0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]),
        .write_data(write_data[0]), .read_data(read_data[0]), .busy(busy[0])
    );

    reg_bus_master #(.RD_LAT(L1), .POLL_MAX(PM), .POLL_GAP(G1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]),
        .write_data(write_data[1]), .read_data(read_data[1]), .busy(busy[1])
    );

    // Register-file responder; optionally changes one register after a given read pulse.
    always_comb begin
        read_data[0] = slave_mem[0][addr[0]];
        read_data[1] = slave_mem[1][addr[1]];
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d]) slave_mem[d][addr[d]] <= write_data[d];
            if (!flip_en) begin
                rd_pulses[d] <= 0;
            end else if (rd_en[d]) begin
                rd_pulses[d] <= rd_pulses[d] + 1;
                if (rd_pulses[d] + 1 == flip_after) slave_mem[d][flip_addr] <= flip_val;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_reg(input int d, input logic [13:0] a, input logic [15:0] v);
        slave_mem[d][a] = v;
        model_mem[d][a] = v;
    endtask

    // Issue one command on instance d and check it against the reference model.
    task automatic run_cmd(input int d, input logic [1:0] op, input logic [13:0] a,
                           input logic [15:0] wd, input logic [15:0] mk, input int hold);
        int lat_l, gap_l, e_lat, e_wr, e_rd, n_wr, n_rd, got;
        logic [15:0] e_rdata, s;
        logic e_err;
        lat_l = (d == 0) ? L0 : L1;
        gap_l = (d == 0) ? G0 : G1;
        e_wr = 0; e_rd = 0; e_rdata = '0; e_err = 1'b1; e_lat = 1;
        case (op)
            2'b00: begin e_lat = 2; e_wr = 1; e_err = 1'b0; end
            2'b01: begin e_lat = 2 + lat_l; e_rd = 1; e_rdata = model_mem[d][a]; e_err = 1'b0; end
`ifdef REG_BUS_MASTER_POLL_EN
            2'b10: begin
                s = '0;
                for (int i = 1; i <= PM; i++) begin
                    s = (flip_en && a == flip_addr && i > flip_after) ? flip_val : model_mem[d][a];
                    e_rd = i;
                    if ((s & mk) == (wd & mk)) begin
                        e_err = 1'b0;
                        break;
                    end
                end
                e_rdata = s;
                e_lat = 1 + e_rd * (1 + lat_l) + (e_rd - 1) * gap_l;
            end
`endif
            default: ;
        endcase

        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
        cmd_valid[d] = 1'b1;
        rsp_ready[d] = 1'b0;
        chk("cmd_ready_idle", 32'(cmd_ready[d]), 32'(1'b1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        n_wr = 0; n_rd = 0; got = -1;
        for (int k = 1; k <= 200; k++) begin
            if (rsp_valid[d]) begin
                got = k;
                break;
            end
            chk("busy_active", 32'(busy[d]), 32'(1'b1));
            chk("wr_rd_exclusive", 32'(wr_en[d] & rd_en[d]), 32'(1'b0));
            if (wr_en[d]) begin
                n_wr++;
                chk("wr_addr", 32'(addr[d]), 32'(a));
                chk("wr_data", 32'(write_data[d]), 32'(wd));
            end
            if (rd_en[d]) begin
                n_rd++;
                chk("rd_addr", 32'(addr[d]), 32'(a));
            end
            @(negedge clk);
        end
        chk("rsp_latency", 32'(got), 32'(e_lat));
        chk("wr_pulses", 32'(n_wr), 32'(e_wr));
        chk("rd_pulses", 32'(n_rd), 32'(e_rd));
        chk("rsp_rdata", 32'(rsp_rdata[d]), 32'(e_rdata));
        chk("rsp_err", 32'(rsp_err[d]), 32'(e_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[d]), 32'(1'b1));
            chk("hold_rdata", 32'(rsp_rdata[d]), 32'(e_rdata));
            chk("hold_err", 32'(rsp_err[d]), 32'(e_err));
            chk("hold_cmd_ready", 32'(cmd_ready[d]), 32'(1'b0));
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid[d]), 32'(1'b0));
        chk("post_cmd_ready", 32'(cmd_ready[d]), 32'(1'b1));
        chk("addr_held", 32'(addr[d]), 32'(a));
        chk("wdata_held", 32'(write_data[d]), 32'(wd));
        if (op == 2'b00) model_mem[d][a] = wd;
        $display("tx dut%0d op=%0d addr=%h wdata=%h mask=%h -> rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
                 d, op, a, wd, mk, rsp_rdata[d], rsp_err[d], got, n_rd, n_wr);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [13:0] r_a;
        logic [15:0] r_wd, r_mk;
        int          r_d;

        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            for (int i = 0; i < 16384; i++) begin
                slave_mem[d][i] = '0;
                model_mem[d][i] = '0;
            end
        end

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'(1'b0));
            chk("rst_busy", 32'(busy[d]), 32'(1'b0));
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'(1'b0));
            chk("rst_wr_en", 32'(wr_en[d]), 32'(1'b0));
            chk("rst_rd_en", 32'(rd_en[d]), 32'(1'b0));
            chk("rst_addr", 32'(addr[d]), 32'(0));
        end
        rst_n = 1'b1;
        #1;
        chk("release_cmd_ready0", 32'(cmd_ready[0]), 32'(1'b1));

        // Directed: write then read-back, reads at both latencies
        run_cmd(0, 2'b00, 14'h101, 16'h0020, 16'h0000, 0);
        run_cmd(1, 2'b00, 14'h101, 16'h0020, 16'h0000, 0);
        run_cmd(0, 2'b01, 14'h101, 16'h0000, 16'h0000, 0);
        set_reg(0, 14'h111, 16'h0003);
        set_reg(1, 14'h111, 16'h0003);
        run_cmd(0, 2'b01, 14'h111, 16'h0000, 16'h0000, 0);
        run_cmd(1, 2'b01, 14'h111, 16'h0000, 16'h0000, 0);

        // Poll where status changes before the 3rd read
        set_reg(0, 14'h111, 16'h0000);
        flip_addr = 14'h111; flip_val = 16'h0001; flip_after = 2; flip_en = 1'b1;
        run_cmd(0, 2'b10, 14'h111, 16'h0001, 16'h000F, 0);
`ifdef REG_BUS_MASTER_POLL_EN
        model_mem[0][14'h111] = 16'h0001;
`endif
        flip_en = 1'b0;

        // Poll stuck at zero, poll on the zero-gap instance, reserved op
        run_cmd(0, 2'b10, 14'h112, 16'h0001, 16'h000F, 0);
        run_cmd(1, 2'b10, 14'h112, 16'h0001, 16'h000F, 0);
        run_cmd(1, 2'b11, 14'h113, 16'hABCD, 16'hFFFF, 0);

        // Backpressure on the response
        run_cmd(0, 2'b01, 14'h101, 16'h0000, 16'h0000, 10);

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            r_d  = int'($urandom_range(0, 1));
            r_op = 2'($urandom_range(0, 3));
            r_a  = 14'h100 + 14'($urandom_range(0, 7));
            r_mk = 16'($urandom);
            r_wd = 16'($urandom);
            if (r_op == 2'b10 && $urandom_range(0, 1) == 1)
                r_wd = model_mem[r_d][r_a] ^ (16'($urandom) & ~r_mk);
            run_cmd(r_d, r_op, r_a, r_wd, r_mk, int'($urandom_range(0, 2)));
        end

        // Reset asserted while dut1 sits in WAIT
        @(negedge clk);
        cmd_op = 2'b01; cmd_addr = 14'h111; cmd_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        chk("pre_rst_rd_en", 32'(rd_en[1]), 32'(1'b1));
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy[1]), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy[1]), 32'(1'b0));
        chk("mid_rst_addr", 32'(addr[1]), 32'(0));
        chk("mid_rst_write_data", 32'(write_data[1]), 32'(0));
        chk("mid_rst_rsp_rdata", 32'(rsp_rdata[1]), 32'(0));
        chk("mid_rst_rsp_err", 32'(rsp_err[1]), 32'(1'b0));
        chk("mid_rst_rsp_valid", 32'(rsp_valid[1]), 32'(1'b0));
        chk("mid_rst_rd_en", 32'(rd_en[1]), 32'(1'b0));
        chk("mid_rst_wr_en", 32'(wr_en[1]), 32'(1'b0));
        chk("mid_rst_cmd_ready", 32'(cmd_ready[1]), 32'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready[1]), 32'(1'b1));
        rsp_ready[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid[1]), 32'(1'b0));
        end
        rsp_ready[1] = 1'b0;

        // Master still functional after reset
        run_cmd(1, 2'b01, 14'h101, 16'h0000, 16'h0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
